alu_control_unit: RTL and testbench
===================================

Name: alu_control_unit

Overview:
- ALU decode stage of the RV32I core.
- Maps the main decoder's 2-bit ALU_op plus instruction funct3 and bit 30 to a 4-bit ALUControl code for the ALU.
- Output is registered: one clock of latency, asynchronous active-high reset.
- Sits between the main control unit and the ALU in the execute path.

Parameters:
- None. All code widths are fixed: ALU_op 2, funct3 3, ALUControl 4.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- ALU_op  input  2  operation class from the main decoder: 00 load/store/address add, 01 branch compare, 10 R-type, 11 I-type ALU.
- funct3  input  3  instr[14:12].
- bit30  input  1  instr[30]; selects SUB vs ADD and SRA vs SRL.
- ALUControl  output  4  registered ALU operation code.

Behaviour:
- ALUControl codes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0011 XOR
  - 0100 SLL
  - 0101 SRL
  - 0110 SUB
  - 0111 SRA
  - 1000 SLT
  - 1001 SLTU
  - All other codes are never produced.
- Reset:
  - While rst=1, ALUControl=0010 (ADD), regardless of clk.
  - Assertion takes effect immediately, without waiting for a clock edge.
  - After deassertion, the first rising edge loads the decoded value.
- Latency: the value decoded from the inputs sampled at rising edge N appears on ALUControl after edge N and holds until edge N+1. There is no enable; the register loads every cycle.
- ALU_op=00: ADD (0010). funct3 and bit30 are ignored (e.g. bit30=1 still gives 0010).
- ALU_op=01: SUB (0110). funct3 and bit30 are ignored.
- ALU_op=10 (R-type), by funct3:
  - 000: bit30=0 -> ADD 0010; bit30=1 -> SUB 0110.
  - 001: SLL 0100
  - 010: SLT 1000
  - 011: SLTU 1001
  - 100: XOR 0011
  - 101: bit30=0 -> SRL 0101; bit30=1 -> SRA 0111.
  - 110: OR 0001
  - 111: AND 0000
  - bit30 is ignored except for funct3 000 and 101.
- ALU_op=11 (I-type ALU): same table as 10, with two differences:
  - funct3 000 is always ADD (0010); bit30 is ignored because ADDI has no SUBI.
  - funct3 101 still uses bit30 (SRAI vs SRLI).
- Decode is fully specified. Every input combination maps to a legal code, and X-free inputs never produce X on the output.
- Input changes between clock edges have no effect on ALUControl until the next rising edge.
- Simultaneous rst and clock edge: reset wins; output stays 0010.
- Reset asserted mid-operation: output forced to 0010 asynchronously. The previous value is discarded, and there is no other state to clear.

Test Plan:
- Reset and reset priority: assert rst with ALU_op=10, funct3=111 -> ALUControl=0010 immediately. Hold rst through two clock edges -> stays 0010. Release rst -> next edge gives 0000.
- Load/store and branch classes:
  - ALU_op=00, funct3=000, bit30=1 -> 0010.
  - Then ALU_op=00, bit30=0 -> 0010.
  - Then ALU_op=01 -> 0110.
  - Check each value one edge after it is applied.
- R-type sweep, ALU_op=10:
  - funct3=000: bit30=0 -> 0010; bit30=1 -> 0110.
  - funct3=111, bit30=0 -> 0000; funct3=110, bit30=0 -> 0001.
  - funct3=100 -> 0011, 001 -> 0100, 010 -> 1000, 011 -> 1001.
  - funct3=101: bit30=0 -> 0101; bit30=1 -> 0111.
- I-type, ALU_op=11:
  - funct3=000 with bit30=1 -> 0010 (not SUB).
  - funct3=101: bit30=1 -> 0111; bit30=0 -> 0101.
  - funct3=111 -> 0000.
- Latency and timing:
  - Change inputs mid-cycle from ADD to SUB -> ALUControl changes only at the next rising edge.
  - Assert rst asynchronously mid-cycle while the output is 0110 -> drops to 0010 before any clock edge.
- Exhaustive: all 64 combinations of ALU_op, funct3 and bit30 against the reference table, each checked one cycle after application; no X on ALUControl.

Source files
------------

// File: rtl/alu_control_unit.sv
// ALU control decode for the RV32I execute path.
// Turns the main decoder's operation class plus funct3/instr[30] into the
// 4-bit ALU operation code, registered with one clock of latency.
module alu_control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] ALU_op,
  input  logic [2:0] funct3,
  input  logic       bit30,
  output logic [3:0] ALUControl
);

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [1:0] OP_MEM    = 2'b00;
  localparam logic [1:0] OP_BRANCH = 2'b01;
  localparam logic [1:0] OP_RTYPE  = 2'b10;

  logic [3:0] alu_ctrl_next;

  // Decode class/funct3/bit30 into the next ALU operation code.
  always_comb begin
    alu_ctrl_next = ALU_ADD;
    case (ALU_op)
      OP_MEM:    alu_ctrl_next = ALU_ADD;
      OP_BRANCH: alu_ctrl_next = ALU_SUB;
      default: begin
        // R-type and I-type share the funct3 table; only R-type honours
        // bit30 on funct3 000 since there is no SUBI. Shifts use bit30 in both.
        case (funct3)
          3'b000: alu_ctrl_next = (ALU_op == OP_RTYPE && bit30) ? ALU_SUB : ALU_ADD;
          3'b001: alu_ctrl_next = ALU_SLL;
          3'b010: alu_ctrl_next = ALU_SLT;
          3'b011: alu_ctrl_next = ALU_SLTU;
          3'b100: alu_ctrl_next = ALU_XOR;
          3'b101: alu_ctrl_next = bit30 ? ALU_SRA : ALU_SRL;
          3'b110: alu_ctrl_next = ALU_OR;
          default: alu_ctrl_next = ALU_AND;
        endcase
      end
    endcase
  end

  // Output register: loads every cycle, reset forces ADD immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ALUControl <= ALU_ADD;
    end else begin
      ALUControl <= alu_ctrl_next;
    end
  end

endmodule

// File: tb/tb_alu_control_unit.sv
// Directed + exhaustive bench for alu_control_unit with an expected-value queue.
module tb_alu_control_unit;

  logic       clk;
  logic       rst;
  logic [1:0] ALU_op;
  logic [2:0] funct3;
  logic       bit30;
  logic [3:0] ALUControl;

  int compared = 0;
  int mismatched = 0;
  logic [3:0] exp_q[$];

  alu_control_unit dut (
    .clk(clk),
    .rst(rst),
    .ALU_op(ALU_op),
    .funct3(funct3),
    .bit30(bit30),
    .ALUControl(ALUControl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference decode, written from the opcode table.
  function automatic logic [3:0] ref_code(input logic [1:0] op, input logic [2:0] f3,
                                          input logic b30);
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b0110;
    if (f3 == 3'b000) begin
      if (op == 2'b10 && b30) return 4'b0110;
      return 4'b0010;
    end
    if (f3 == 3'b101) return b30 ? 4'b0111 : 4'b0101;
    if (f3 == 3'b001) return 4'b0100;
    if (f3 == 3'b010) return 4'b1000;
    if (f3 == 3'b011) return 4'b1001;
    if (f3 == 3'b100) return 4'b0011;
    if (f3 == 3'b110) return 4'b0001;
    return 4'b0000;
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive inputs on the falling edge and queue the expected result.
  task automatic apply(input logic [1:0] op, input logic [2:0] f3, input logic b30);
    @(negedge clk);
    ALU_op = op;
    funct3 = f3;
    bit30  = b30;
    exp_q.push_back(ref_code(op, f3, b30));
  endtask

  // Sample just after the next rising edge and compare with the queue head.
  task automatic collect(input string tag);
    logic [3:0] exp;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, ALUControl, 4'bxxxx);
    end else begin
      exp = exp_q.pop_front();
      check(tag, ALUControl, exp);
    end
  endtask

  task automatic step(input string tag, input logic [1:0] op, input logic [2:0] f3,
                      input logic b30);
    apply(op, f3, b30);
    collect(tag);
  endtask

  initial begin
    rst    = 1'b0;
    ALU_op = 2'b10;
    funct3 = 3'b111;
    bit30  = 1'b0;

    // Reset takes effect before any clock edge.
    #2 rst = 1'b1;
    #1 check("reset_immediate", ALUControl, 4'b0010);
    @(posedge clk); @(posedge clk); #1;
    check("reset_held", ALUControl, 4'b0010);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(4'b0000);
    collect("reset_release_and");

    // Load/store and branch classes.
    step("mem_b30_1", 2'b00, 3'b000, 1'b1);
    step("mem_b30_0", 2'b00, 3'b000, 1'b0);
    step("branch",    2'b01, 3'b000, 1'b0);

    // R-type sweep.
    step("r_add",  2'b10, 3'b000, 1'b0);
    step("r_sub",  2'b10, 3'b000, 1'b1);
    step("r_and",  2'b10, 3'b111, 1'b0);
    step("r_or",   2'b10, 3'b110, 1'b0);
    step("r_xor",  2'b10, 3'b100, 1'b0);
    step("r_sll",  2'b10, 3'b001, 1'b0);
    step("r_slt",  2'b10, 3'b010, 1'b0);
    step("r_sltu", 2'b10, 3'b011, 1'b0);
    step("r_srl",  2'b10, 3'b101, 1'b0);
    step("r_sra",  2'b10, 3'b101, 1'b1);

    // I-type.
    step("i_addi_b30", 2'b11, 3'b000, 1'b1);
    step("i_srai",     2'b11, 3'b101, 1'b1);
    step("i_srli",     2'b11, 3'b101, 1'b0);
    step("i_andi",     2'b11, 3'b111, 1'b0);

    // Mid-cycle input change only shows up at the next rising edge.
    step("lat_add", 2'b00, 3'b000, 1'b0);
    #2;
    ALU_op = 2'b01;
    exp_q.push_back(4'b0110);
    #1 check("lat_hold_before_edge", ALUControl, 4'b0010);
    collect("lat_sub_after_edge");

    // Asynchronous reset mid-cycle while output is SUB.
    #2 rst = 1'b1;
    #1 check("async_rst_mid_cycle", ALUControl, 4'b0010);
    @(negedge clk);
    rst = 1'b0;

    // Exhaustive sweep of all 64 input combinations.
    for (int i = 0; i < 64; i++) begin
      logic [5:0] v;
      v = 6'(i);
      apply(v[5:4], v[3:1], v[0]);
      collect($sformatf("exh_op%b_f%b_b%b", v[5:4], v[3:1], v[0]));
      compared++;
      assert (!$isunknown(ALUControl)) else begin
        mismatched++;
        $error("FAIL exh_no_x_%0d observed=%b expected=known", i, ALUControl);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
